// File: rtl/cpu_mon_pkg.sv
// Shared types for the CPU run monitor: FSM states and the {PC, IR} trace entry layout.
package cpu_mon_pkg;

  // Widest observation bus a trace entry can hold; narrower cores zero-extend into it.
  localparam int MON_XLEN = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALTED,
    TIMEOUT
  } monState_t;

  typedef struct packed {
    logic [MON_XLEN-1:0] pc;
    logic [MON_XLEN-1:0] ir;
  } traceEntry_t;

endpackage

// File: rtl/cpu_mon_trace_buf.sv
// Circular trace buffer: pushes one entry per write, saturating fill count,
// and a combinational read addressed relative to the newest entry (0 = newest).
module cpu_mon_trace_buf
  import cpu_mon_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     we,
  input  traceEntry_t              wrData,
  input  logic [$clog2(DEPTH)-1:0] rdIdx,
  output traceEntry_t              rdData,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  traceEntry_t   mem [DEPTH];
  logic [AW-1:0] wrPtr;

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      count <= '0;
    end else if (we) begin
      wrPtr <= wrPtr + AW'(1);
      if (count != (AW+1)'(DEPTH))
        count <= count + (AW+1)'(1);
    end
  end

  // Storage is left unreset; anything at or beyond count is meaningless anyway.
  always_ff @(posedge clk) begin
    if (we)
      mem[wrPtr] <= wrData;
  end

  // DEPTH is a power of two, so AW-bit arithmetic wraps the index for free.
  always_comb begin
    rdData = mem[wrPtr - AW'(1) - rdIdx];
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor for the multicycle RISC-V core: counts RUN cycles and retires,
// traces recent {PC, IR} pairs and flags halt (self-loop) or watchdog timeout.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int XLEN         = MON_XLEN,
  parameter int STATE_W      = 4,
  parameter int FETCH_STATE  = 0,
  parameter int DECODE_STATE = 1,
  parameter int TRACE_DEPTH  = 16,
  parameter int CNT_W        = 32,
  parameter int WATCHDOG     = 1024,
  parameter int HALT_REPEAT  = 3
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [STATE_W-1:0]             stateNum,
  input  logic [XLEN-1:0]                PC,
  input  logic [XLEN-1:0]                IR,
  input  logic                           clear,
  input  logic [$clog2(TRACE_DEPTH)-1:0] rd_idx,
  output logic [XLEN-1:0]                rd_pc,
  output logic [XLEN-1:0]                rd_ir,
  output logic [$clog2(TRACE_DEPTH):0]   trace_count,
  output logic [CNT_W-1:0]               cycle_count,
  output logic [CNT_W-1:0]               instr_count,
  output logic                           retire,
  output logic                           running,
  output logic                           halted,
  output logic                           timeout
);

  localparam int WD_W = $clog2(WATCHDOG);
  localparam int SC_W = $clog2(HALT_REPEAT + 1);

  monState_t          state, stateNext;
  logic [STATE_W-1:0] prevState;
  logic               firstCycle;
  logic [XLEN-1:0]    fetchPc, lastPc;
  logic               fetchValid, haveLast;
  logic [SC_W-1:0]    sameCnt, sameNext;
  logic [WD_W-1:0]    wdCnt;
  logic               rstAll, fetchEntry, decodeEntry, retireEv, haltHit, wdExpire;
  traceEntry_t        wrEntry, rdEntry;

  always_comb begin
    rstAll      = reset | clear;
    fetchEntry  = (stateNum == STATE_W'(FETCH_STATE)) &&
                  ((prevState != STATE_W'(FETCH_STATE)) || firstCycle);
    decodeEntry = (stateNum == STATE_W'(DECODE_STATE)) &&
                  (prevState != STATE_W'(DECODE_STATE));
    retireEv    = decodeEntry && fetchValid && (state == RUN);
    sameNext    = (haveLast && (fetchPc == lastPc)) ? sameCnt + SC_W'(1) : SC_W'(1);
    haltHit     = retireEv && (sameNext >= SC_W'(HALT_REPEAT));
    // A retire in the expiry cycle rescues the watchdog, which also makes halt win.
    wdExpire    = !retireEv && (wdCnt == WD_W'(WATCHDOG - 1));
    wrEntry.pc  = MON_XLEN'(fetchPc);
    wrEntry.ir  = MON_XLEN'(IR);
  end

  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    if (fetchEntry) stateNext = RUN;
      RUN: begin
        if (haltHit)
          stateNext = HALTED;
        else if (wdExpire)
          stateNext = TIMEOUT;
      end
      default: stateNext = state;
    endcase
  end

  always_ff @(posedge clk) begin
    prevState <= stateNum;
    if (rstAll) begin
      state       <= IDLE;
      firstCycle  <= 1'b1;
      fetchPc     <= '0;
      fetchValid  <= 1'b0;
      lastPc      <= '0;
      haveLast    <= 1'b0;
      sameCnt     <= '0;
      wdCnt       <= '0;
      cycle_count <= '0;
      instr_count <= '0;
      retire      <= 1'b0;
    end else begin
      state      <= stateNext;
      firstCycle <= 1'b0;
      retire     <= retireEv;
      // The fetch-entry PC is the instruction address; it is consumed by one retire.
      if (state == IDLE || state == RUN) begin
        if (fetchEntry) begin
          fetchPc    <= PC;
          fetchValid <= 1'b1;
        end else if (retireEv) begin
          fetchValid <= 1'b0;
        end
      end
      if (state == RUN) begin
        if (cycle_count != '1)
          cycle_count <= cycle_count + CNT_W'(1);
        if (retireEv) begin
          if (instr_count != '1)
            instr_count <= instr_count + CNT_W'(1);
          wdCnt    <= '0;
          lastPc   <= fetchPc;
          haveLast <= 1'b1;
          sameCnt  <= sameNext;
        end else if (!wdExpire) begin
          wdCnt <= wdCnt + WD_W'(1);
        end
      end
    end
  end

  always_comb begin
    running = (state == RUN);
    halted  = (state == HALTED);
    timeout = (state == TIMEOUT);
    rd_pc   = XLEN'(rdEntry.pc);
    rd_ir   = XLEN'(rdEntry.ir);
  end

  cpu_mon_trace_buf #(
    .DEPTH(TRACE_DEPTH)
  ) traceBuf (
    .clk    (clk),
    .reset  (rstAll),
    .we     (retireEv && !rstAll),
    .wrData (wrEntry),
    .rdIdx  (rd_idx),
    .rdData (rdEntry),
    .count  (trace_count)
  );

endmodule

// File: doc/cpu_run_monitor.md
Name: cpu_run_monitor

Overview:
- Synthesizable run monitor that attaches to the multicycle RISC-V core's observation outputs: state number, PC and IR.
- Counts cycles and retired instructions.
- Keeps a circular trace of the last TRACE_DEPTH instructions as {PC, IR}.
- Detects halt (self-loop) and watchdog timeout, replacing the fixed cycle integer and free-running observation in the simulation harness with parametrised on-chip logic.

Parameters:
- XLEN, 64, width of PC/IR observation buses.
- STATE_W, 4, width of the core's state number.
- FETCH_STATE, 0, state encoding of the instruction-fetch state.
- DECODE_STATE, 1, state encoding of the decode state.
- TRACE_DEPTH, 16, trace entries; must be a power of 2, at least 2.
- CNT_W, 32, width of the cycle and instruction counters.
- WATCHDOG, 1024, cycles without a retire before timeout; must be at least 2.
- HALT_REPEAT, 3, consecutive retires at the same PC that declare a halt; must be at least 2.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- stateNum  in  STATE_W  core FSM state
- PC  in  XLEN  core program counter
- IR  in  XLEN  core instruction register
- clear  in  1  synchronous soft clear: same effect as reset, trace contents excepted
- rd_idx  in  $clog2(TRACE_DEPTH)  trace read index; 0 = most recent entry
- rd_pc  out  XLEN  PC of the selected trace entry
- rd_ir  out  XLEN  IR of the selected trace entry
- trace_count  out  $clog2(TRACE_DEPTH)+1  number of valid trace entries
- cycle_count  out  CNT_W  cycles spent in RUN
- instr_count  out  CNT_W  retired instructions
- retire  out  1  one-cycle pulse per retire
- running  out  1  FSM is in RUN
- halted  out  1  halt detected (sticky)
- timeout  out  1  watchdog expired (sticky)

Behaviour:
- Reset (reset or clear):
  - FSM goes to IDLE.
  - All counters, pointers and trace_count go to 0.
  - retire, running, halted and timeout go to 0.
  - Trace RAM contents are don't-care; reads at index >= trace_count are undefined.
- Edge detection: prev_state is registered every cycle.
  - fetch_entry = (stateNum == FETCH_STATE) && (prev_state != FETCH_STATE || first cycle after reset).
  - decode_entry = (stateNum == DECODE_STATE) && (prev_state != DECODE_STATE).
- On fetch_entry: latch PC into fetch_pc. The core updates PC during fetch, so the entry value is the instruction address.
- On decode_entry, with a valid fetch_pc:
  - Retire: push {fetch_pc, IR} at wr_ptr; wr_ptr advances modulo TRACE_DEPTH.
  - trace_count increments, saturating at TRACE_DEPTH.
  - instr_count increments, saturating at all-ones.
  - retire is registered high for exactly one cycle, in the cycle after decode_entry.
- Trace read is combinational: entry at (wr_ptr - 1 - rd_idx) mod TRACE_DEPTH. Wrap-around overwrites the oldest entry.
- FSM states:
  - IDLE: move to RUN on the first fetch_entry.
  - RUN:
    - cycle_count increments every cycle, saturating.
    - Watchdog counter resets to 0 on each retire and otherwise increments.
    - Watchdog reaching WATCHDOG-1 without a retire moves to TIMEOUT.
    - A retire whose fetch_pc equals the previous retire's PC increments same_cnt; a different PC sets same_cnt to 1.
    - same_cnt reaching HALT_REPEAT moves to HALTED.
  - HALTED / TIMEOUT: terminal; counters and trace are frozen. Only reset or clear exits.
- Simultaneous events:
  - If the halt condition and watchdog expiry occur in the same cycle, HALTED wins.
  - A retire in the expiry cycle still counts, and the watchdog does not expire.
  - reset and clear together act as reset.
- The trace does not record while in IDLE.
- Reset or clear mid-instruction discards fetch_pc. The next retire requires a fresh fetch_entry.
- Outputs:
  - running = (state == RUN).
  - halted and timeout are decoded from the FSM state.
  - All outputs are registered except rd_pc and rd_ir.

Decomposition:
- Package cpu_mon_pkg holds the FSM state enum {IDLE, RUN, HALTED, TIMEOUT} and a trace entry struct {pc, ir} parametrised through XLEN localparams.
- One sub-module, cpu_mon_trace_buf: circular buffer with write port, wr_ptr, saturating count and relative-index read.
- The FSM and counters stay in the top level.

Test Plan:
- Reset, then core cycles states 0,1,2,0,1,2 with PC 0x0 then 0x4 → two retire pulses, instr_count=2, rd_idx0 gives PC 0x4, rd_idx1 gives PC 0x0, running=1.
- 20 distinct instructions with TRACE_DEPTH=16 → trace_count=16, rd_idx0 gives the 20th PC, rd_idx15 gives the 5th PC (wrap-around).
- Same PC 0x40 retired 3 times (HALT_REPEAT=3) → halted=1 after the third retire; cycle_count and instr_count frozen afterwards even with continued stimulus.
- Core stuck in state 2 for WATCHDOG cycles after a retire → timeout=1 at exactly WATCHDOG cycles after the last retire.
- clear asserted mid-decode, then normal fetch → all counters 0, state IDLE then RUN; first retire PC equals the post-clear fetch PC.
- Halt condition and watchdog expiry arranged in the same cycle → halted=1, timeout=0.
